// File: rtl/t06_apple_spawn_ctrl.sv
// t06_apple_spawn_ctrl: apple (re)spawn sequencer for the snake game.
// Random candidates are screened against the playfield bounds and then
// offered to the external occupancy checker. After MAX_TRIES rejects the
// sequencer falls back to a raster scan of the interior.
// Optional feature macro: APPLE_SPAWN_STATS_EN (adds spawn_count, last_tries).
module t06_apple_spawn_ctrl #(
  parameter int unsigned MAX_TRIES   = 15,
  parameter int unsigned CHK_TIMEOUT = 8,
  parameter logic [7:0]  RESET_LOC   = 8'h55
) (
  input  logic       system_clk,
  input  logic       nreset,
  input  logic       good_collision,
  input  logic [7:0] rand_val,
  input  logic [3:0] XMAX,
  input  logic [3:0] XMIN,
  input  logic [3:0] YMAX,
  input  logic [3:0] YMIN,
  output logic       cand_req,
  output logic [7:0] cand_xy,
  input  logic       chk_done,
  input  logic       chk_ok,
  output logic [7:0] apple_location,
  output logic       apple_valid,
  output logic       busy,
  output logic       spawn_fail
`ifdef APPLE_SPAWN_STATS_EN
  ,
  output logic [7:0] spawn_count,
  output logic [3:0] last_tries
`endif
);

  localparam int unsigned TW = $clog2(CHK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    WAIT_CHK,
    SCAN,
    SCAN_WAIT,
    COMMIT
  } state_t;

  state_t          state;
  logic            pending;
  logic [3:0]      tries;
  logic [TW-1:0]   timer;
  logic [3:0]      scan_x;
  logic [3:0]      scan_y;

  logic            degenerate;
  logic            rand_inb;
  logic [3:0]      tries_inc;
  logic            tries_last;
  logic            timer_exp;
  logic            scan_x_last;
  logic            scan_y_last;

  // Bounds screening, retry limit and timeout decode.
  always_comb begin
    degenerate  = ({1'b0, XMAX} <= ({1'b0, XMIN} + 5'd1)) ||
                  ({1'b0, YMAX} <= ({1'b0, YMIN} + 5'd1));
    rand_inb    = (rand_val[3:0] > XMIN) && (rand_val[3:0] < XMAX) &&
                  (rand_val[7:4] > YMIN) && (rand_val[7:4] < YMAX);
    tries_inc   = (tries == 4'hF) ? 4'hF : tries + 4'd1;
    tries_last  = ({1'b0, tries} + 5'd1) >= 5'(MAX_TRIES);
    timer_exp   = (timer == TW'(CHK_TIMEOUT - 1));
    scan_x_last = ({1'b0, scan_x} + 5'd1) >= {1'b0, XMAX};
    scan_y_last = ({1'b0, scan_y} + 5'd1) >= {1'b0, YMAX};
  end

  // Spawn sequencer with registered outputs.
  always_ff @(posedge system_clk or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      pending        <= 1'b0;
      tries          <= '0;
      timer          <= '0;
      scan_x         <= '0;
      scan_y         <= '0;
      cand_req       <= 1'b0;
      cand_xy        <= '0;
      apple_location <= RESET_LOC;
      apple_valid    <= 1'b0;
      busy           <= 1'b0;
      spawn_fail     <= 1'b0;
`ifdef APPLE_SPAWN_STATS_EN
      spawn_count    <= '0;
      last_tries     <= '0;
`endif
    end else begin
      cand_req <= 1'b0;
      if (good_collision && (state != IDLE)) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (good_collision || pending) begin
            state       <= DRAW;
            busy        <= 1'b1;
            apple_valid <= 1'b0;
            spawn_fail  <= 1'b0;
            tries       <= '0;
            pending     <= 1'b0;
          end
        end

        DRAW: begin
          if (degenerate) begin
            spawn_fail <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else if (rand_inb) begin
            cand_xy  <= rand_val;
            cand_req <= 1'b1;
            timer    <= '0;
            state    <= WAIT_CHK;
          end else begin
            tries <= tries_inc;
            if (tries_last) begin
              // tries parks at 4'hF for the scan so a scan commit reports 4'hF.
              tries  <= 4'hF;
              scan_x <= XMIN + 4'd1;
              scan_y <= YMIN + 4'd1;
              state  <= SCAN;
            end else begin
              state <= DRAW;
            end
          end
        end

        WAIT_CHK: begin
          if (chk_done && chk_ok) begin
            state <= COMMIT;
          end else if (chk_done || timer_exp) begin
            tries <= tries_inc;
            if (tries_last) begin
              tries  <= 4'hF;
              scan_x <= XMIN + 4'd1;
              scan_y <= YMIN + 4'd1;
              state  <= SCAN;
            end else begin
              state <= DRAW;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        SCAN: begin
          cand_xy  <= {scan_y, scan_x};
          cand_req <= 1'b1;
          timer    <= '0;
          state    <= SCAN_WAIT;
        end

        SCAN_WAIT: begin
          if (chk_done && chk_ok) begin
            state <= COMMIT;
          end else if (chk_done || timer_exp) begin
            if (scan_x_last && scan_y_last) begin
              spawn_fail <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              if (scan_x_last) begin
                scan_x <= XMIN + 4'd1;
                scan_y <= (scan_y == 4'hF) ? 4'hF : scan_y + 4'd1;
              end else begin
                scan_x <= scan_x + 4'd1;
              end
              state <= SCAN;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end

        COMMIT: begin
          apple_location <= cand_xy;
          apple_valid    <= 1'b1;
          busy           <= 1'b0;
          state          <= IDLE;
`ifdef APPLE_SPAWN_STATS_EN
          spawn_count    <= spawn_count + 8'd1;
          last_tries     <= tries;
`endif
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t06_apple_spawn_ctrl.sv
// Self-checking bench for t06_apple_spawn_ctrl.
// Honours APPLE_SPAWN_STATS_EN when defined.
module tb_t06_apple_spawn_ctrl;

  localparam int unsigned MAX_TRIES   = 15;
  localparam int unsigned CHK_TIMEOUT = 8;
  localparam logic [7:0]  RESET_LOC   = 8'h55;

  logic       system_clk = 1'b0;
  logic       nreset;
  logic       good_collision;
  logic [7:0] rand_val;
  logic [3:0] bxmax, bxmin, bymax, bymin;
  logic       cand_req;
  logic [7:0] cand_xy;
  logic       chk_done, chk_ok;
  logic [7:0] apple_location;
  logic       apple_valid, busy, spawn_fail;
`ifdef APPLE_SPAWN_STATS_EN
  logic [7:0] spawn_count;
  logic [3:0] last_tries;
  int         exp_count = 0;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_loc   = RESET_LOC;
  logic       exp_valid = 1'b0;
  logic       exp_fail  = 1'b0;

  // Directed overrides: candidate values and checker answers (0 ok, 1 reject, 2 silent).
  logic [7:0] draw_q[$];
  int         kind_q[$];
  int         dly_q[$];
  int         pend_left      = 0;
  bit         pend_at_commit = 1'b0;
  int         ok_pct_draw    = 30;
  int         ok_pct_scan    = 10;
  bit         in_scan        = 1'b0;

  t06_apple_spawn_ctrl #(
    .MAX_TRIES  (MAX_TRIES),
    .CHK_TIMEOUT(CHK_TIMEOUT),
    .RESET_LOC  (RESET_LOC)
  ) dut (
    .system_clk    (system_clk),
    .nreset        (nreset),
    .good_collision(good_collision),
    .rand_val      (rand_val),
    .XMAX          (bxmax),
    .XMIN          (bxmin),
    .YMAX          (bymax),
    .YMIN          (bymin),
    .cand_req      (cand_req),
    .cand_xy       (cand_xy),
    .chk_done      (chk_done),
    .chk_ok        (chk_ok),
    .apple_location(apple_location),
    .apple_valid   (apple_valid),
    .busy          (busy),
    .spawn_fail    (spawn_fail)
`ifdef APPLE_SPAWN_STATS_EN
    ,
    .spawn_count   (spawn_count),
    .last_tries    (last_tries)
`endif
  );

  always #5 system_clk = ~system_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit inb(input logic [7:0] v);
    return (int'(v[3:0]) > int'(bxmin)) && (int'(v[3:0]) < int'(bxmax)) &&
           (int'(v[7:4]) > int'(bymin)) && (int'(v[7:4]) < int'(bymax));
  endfunction

  function automatic bit degen();
    return (int'(bxmax) - int'(bxmin) < 2) || (int'(bymax) - int'(bymin) < 2);
  endfunction

  task automatic check_idle_state(input string tag);
    chk({tag, "_loc"},   32'(apple_location), 32'(exp_loc));
    chk({tag, "_valid"}, 32'(apple_valid),    32'(exp_valid));
    chk({tag, "_fail"},  32'(spawn_fail),     32'(exp_fail));
    chk({tag, "_busy"},  32'(busy),           0);
    chk({tag, "_req"},   32'(cand_req),       0);
  endtask

  // Quiet cycles with checker noise; nothing may start or change.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      rand_val = 8'($urandom);
      chk_done = 1'($urandom_range(1));
      chk_ok   = 1'($urandom_range(1));
      @(posedge system_clk); #1;
      chk_done = 1'b0;
      check_idle_state("idle");
    end
  endtask

  // Answer one outstanding candidate; returns once the DUT has decided on it.
  task automatic respond(input logic [7:0] v, output bit accepted);
    int kind, d, r, pct;
    if (kind_q.size() > 0) begin
      kind = kind_q.pop_front();
      d    = dly_q.pop_front();
    end else begin
      pct  = in_scan ? ok_pct_scan : ok_pct_draw;
      r    = int'($urandom_range(99));
      kind = (r < pct) ? 0 : ((r < pct + (100 - pct) / 2) ? 1 : 2);
      d    = int'($urandom_range(1, CHK_TIMEOUT));
    end
    if (kind == 2) d = int'(CHK_TIMEOUT);
    for (int j = 1; j <= d; j++) begin
      if (kind != 2 && j == d) begin
        chk_done = 1'b1;
        chk_ok   = (kind == 0);
      end
      if (pend_left > 0) begin
        good_collision = 1'b1;
        pend_left--;
      end
      @(posedge system_clk); #1;
      chk_done       = 1'b0;
      chk_ok         = 1'($urandom_range(1));
      good_collision = 1'b0;
      if (j < d) begin
        chk("wait_req",  32'(cand_req), 0);
        chk("hold_xy",   32'(cand_xy),  32'(v));
        chk("wait_busy", 32'(busy),     1);
      end
    end
    accepted = (kind == 0);
  endtask

  // One complete spawn; pulse=0 relies on a pending request to start it.
  task automatic run_spawn(input bit pulse);
    int         tries;
    bit         committed, acc, from_scan;
    logic [7:0] v, loc;
    good_collision = pulse;
    @(posedge system_clk); #1;
    good_collision = 1'b0;
    chk("start_busy",  32'(busy),        1);
    chk("start_valid", 32'(apple_valid), 0);
    chk("start_fail",  32'(spawn_fail),  0);
    if (degen()) begin
      rand_val = 8'($urandom);
      @(posedge system_clk); #1;
      exp_valid = 1'b0;
      exp_fail  = 1'b1;
      check_idle_state("degen");
      pend_left = 0;
      return;
    end
    tries = 0; committed = 1'b0; from_scan = 1'b0; loc = exp_loc; in_scan = 1'b0;
    while (!committed && tries < int'(MAX_TRIES)) begin
      if (draw_q.size() > 0) v = draw_q.pop_front();
      else if ($urandom_range(1) == 1)
        v = {4'($urandom_range(int'(bymin) + 1, int'(bymax) - 1)),
             4'($urandom_range(int'(bxmin) + 1, int'(bxmax) - 1))};
      else v = 8'($urandom);
      rand_val = v;
      chk_done = 1'($urandom_range(1));
      chk_ok   = 1'($urandom_range(1));
      @(posedge system_clk); #1;
      chk_done = 1'b0;
      if (!inb(v)) begin
        chk("oob_noreq", 32'(cand_req), 0);
        tries++;
      end else begin
        chk("draw_req", 32'(cand_req), 1);
        chk("draw_xy",  32'(cand_xy),  32'(v));
        respond(v, acc);
        if (acc) begin committed = 1'b1; loc = v; end
        else tries++;
      end
    end
    if (!committed) begin
      in_scan = 1'b1;
      for (int y = int'(bymin) + 1; y <= int'(bymax) - 1 && !committed; y++) begin
        for (int x = int'(bxmin) + 1; x <= int'(bxmax) - 1 && !committed; x++) begin
          v        = {4'(y), 4'(x)};
          chk_done = 1'($urandom_range(1));
          chk_ok   = 1'($urandom_range(1));
          @(posedge system_clk); #1;
          chk_done = 1'b0;
          chk("scan_req", 32'(cand_req), 1);
          chk("scan_xy",  32'(cand_xy),  32'(v));
          respond(v, acc);
          if (acc) begin committed = 1'b1; loc = v; from_scan = 1'b1; end
        end
      end
      in_scan = 1'b0;
      if (!committed) begin
        exp_valid = 1'b0;
        exp_fail  = 1'b1;
        check_idle_state("scanfail");
        pend_left = 0;
        return;
      end
    end
    good_collision = pend_at_commit;
    @(posedge system_clk); #1;
    good_collision = 1'b0;
    pend_at_commit = 1'b0;
    pend_left      = 0;
    exp_loc   = loc;
    exp_valid = 1'b1;
    exp_fail  = 1'b0;
    check_idle_state("commit");
`ifdef APPLE_SPAWN_STATS_EN
    exp_count = (exp_count + 1) % 256;
    chk("spawn_count", 32'(spawn_count), 32'(exp_count));
    chk("last_tries",  32'(last_tries),  from_scan ? 15 : tries);
`endif
  endtask

  task automatic set_bounds(input int xmin, input int xmax, input int ymin, input int ymax);
    bxmin = 4'(xmin); bxmax = 4'(xmax); bymin = 4'(ymin); bymax = 4'(ymax);
  endtask

  initial begin
    nreset = 1'b0; good_collision = 1'b0; rand_val = '0;
    chk_done = 1'b0; chk_ok = 1'b0;
    set_bounds(0, 11, 0, 11);

    // Reset values
    repeat (3) @(posedge system_clk);
    #1;
    check_idle_state("reset");
    chk("reset_xy", 32'(cand_xy), 0);
    #2 nreset = 1'b1;
    idle_check(2);

    // Single in-bounds draw, checker answers ok: commit five cycles after the eat pulse
    draw_q.push_back(8'h34); kind_q.push_back(0); dly_q.push_back(3);
    run_spawn(1'b1);

    // Out-of-bounds draws issue no request; two checker rejects then ok
    for (int i = 0; i < 3; i++) begin
      draw_q.push_back(8'hF0);
      draw_q.push_back(8'h23);
    end
    kind_q.push_back(1); dly_q.push_back(2);
    kind_q.push_back(1); dly_q.push_back(8);
    kind_q.push_back(0); dly_q.push_back(8);
    run_spawn(1'b1);
    idle_check(2);

    // Silent checker on a 2x2 interior: 15 timeouts, full scan, spawn_fail
    set_bounds(0, 3, 0, 3);
    for (int i = 0; i < int'(MAX_TRIES) + 4; i++) begin
      if (i < int'(MAX_TRIES))
        draw_q.push_back({4'($urandom_range(1, 2)), 4'($urandom_range(1, 2))});
      kind_q.push_back(2); dly_q.push_back(int'(CHK_TIMEOUT));
    end
    run_spawn(1'b1);
    idle_check(3);

    // Two eat pulses while busy merge into exactly one follow-up spawn
    set_bounds(0, 11, 0, 11);
    pend_left = 2;
    draw_q.push_back(8'h34); kind_q.push_back(0); dly_q.push_back(3);
    run_spawn(1'b1);
    run_spawn(1'b0);
    idle_check(6);

    // Eat pulse in the commit cycle is also queued
    pend_at_commit = 1'b1;
    draw_q.push_back(8'h56); kind_q.push_back(0); dly_q.push_back(1);
    run_spawn(1'b1);
    run_spawn(1'b0);
    idle_check(4);

    // Reset while waiting on the checker, late chk_done must not commit
    good_collision = 1'b1;
    @(posedge system_clk); #1;
    good_collision = 1'b0;
    rand_val = 8'h34;
    @(posedge system_clk); #1;
    chk("rst_pre_req", 32'(cand_req), 1);
    @(posedge system_clk); #1;
    @(posedge system_clk); #3;
    nreset = 1'b0;
    #1;
    exp_loc = RESET_LOC; exp_valid = 1'b0; exp_fail = 1'b0;
`ifdef APPLE_SPAWN_STATS_EN
    exp_count = 0;
    chk("rst_count", 32'(spawn_count), 0);
`endif
    check_idle_state("rst_async");
    chk("rst_xy", 32'(cand_xy), 0);
    chk_done = 1'b1; chk_ok = 1'b1;
    @(posedge system_clk); #1;
    check_idle_state("rst_hold");
    #2 nreset = 1'b1;
    chk_done = 1'b1; chk_ok = 1'b1;
    @(posedge system_clk); #1;
    chk_done = 1'b0;
    check_idle_state("rst_late_done");
    idle_check(3);

    // Randomised spawns over random (sometimes degenerate) bounds
    for (int n = 0; n < 30; n++) begin
      int xmin, ymin;
      xmin = int'($urandom_range(0, 6));
      ymin = int'($urandom_range(0, 6));
      set_bounds(xmin, xmin + int'($urandom_range(0, 9)), ymin, ymin + int'($urandom_range(0, 9)));
      ok_pct_draw = ($urandom_range(4) == 0) ? 0 : 30;
      run_spawn(1'b1);
      idle_check(int'($urandom_range(1, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
